// File: rtl/vending_machine_multi.sv
// Parametrised vending controller: coin or card payment, live per-slot inventory with
// restock, sold-out detection, overflow coin rejection and one-coin-per-cycle greedy change.
module vending_machine_multi #(
    parameter int N_PRODUCTS = 8,
    parameter int PRICE_W    = 8,
    parameter int INV_W      = 3,
    parameter int BAL_W      = 9,
    parameter int INIT_STOCK = 4,
    localparam int IDX_W     = (N_PRODUCTS > 1) ? $clog2(N_PRODUCTS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [IDX_W-1:0]              sel,
    input  logic                          select,
    input  logic                          pay_card,
    input  logic [BAL_W-1:0]              card_credit,
    input  logic                          nickel,
    input  logic                          dime,
    input  logic                          quarter,
    input  logic                          dollar,
    input  logic                          cancel,
    input  logic [N_PRODUCTS*PRICE_W-1:0] cost,
    input  logic                          restock_en,
    input  logic [IDX_W-1:0]              restock_idx,
    input  logic [INV_W-1:0]              restock_qty,
    output logic [BAL_W-1:0]              balance,
    output logic                          dispensed,
    output logic [IDX_W-1:0]              dispensed_idx,
    output logic [BAL_W-1:0]              card_debit,
    output logic                          deny,
    output logic                          sold_out,
    output logic                          coin_reject,
    output logic                          coin_q,
    output logic                          coin_d,
    output logic                          coin_n,
    output logic [4:0]                    quart,
    output logic [4:0]                    dim,
    output logic [4:0]                    nick,
    output logic                          busy,
    output logic [N_PRODUCTS*INV_W-1:0]   inventory
);

    // Wide enough for balance + one cycle of coins and for price/credit compares.
    localparam int SW = ((BAL_W > PRICE_W) ? BAL_W : PRICE_W) + 2;

    localparam logic [SW-1:0]    BalMax = {{(SW-BAL_W){1'b0}}, {BAL_W{1'b1}}};
    localparam logic [INV_W:0]   InvMax = {1'b0, {INV_W{1'b1}}};
    localparam logic [INV_W:0]   InvOne = {{INV_W{1'b0}}, 1'b1};

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StCollect = 2'd1;
    localparam logic [1:0] StVend    = 2'd2;
    localparam logic [1:0] StChange  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [BAL_W-1:0] bal_q, bal_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             card_q, card_d;
    logic [4:0]       quart_q, quart_d;
    logic [4:0]       dim_q, dim_d;
    logic [4:0]       nick_q, nick_d;
    logic             deny_q, deny_d;
    logic             sold_q, sold_d;
    logic             rej_q, rej_d;
    logic [INV_W-1:0] inv_q [N_PRODUCTS];
    logic [INV_W-1:0] inv_d [N_PRODUCTS];

    logic [SW-1:0]      coin_sum, bal_ext, bal_plus;
    logic               coin_any, in_accept, coin_ovf;
    logic [BAL_W-1:0]   bal_acc;
    logic               sel_valid;
    logic [PRICE_W-1:0] sel_price, cur_price;
    logic [INV_W-1:0]   sel_inv;
    logic               enter_change;
    logic               in_vend, in_change;

    function automatic logic [PRICE_W-1:0] price_at(input logic [N_PRODUCTS*PRICE_W-1:0] vec,
                                                    input int idx);
        return vec[idx*PRICE_W +: PRICE_W];
    endfunction

    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

    // Coin summation, overflow detection and price/inventory lookup for the current cycle.
    always_comb begin
        coin_sum = '0;
        if (nickel)  coin_sum = coin_sum + SW'(5);
        if (dime)    coin_sum = coin_sum + SW'(10);
        if (quarter) coin_sum = coin_sum + SW'(25);
        if (dollar)  coin_sum = coin_sum + SW'(100);
        coin_any  = nickel | dime | quarter | dollar;
        in_accept = (state_q == StIdle) || (state_q == StCollect);
        bal_ext   = SW'(bal_q);
        bal_plus  = bal_ext + coin_sum;
        coin_ovf  = bal_plus > BalMax;
        bal_acc   = (in_accept && coin_any && !coin_ovf) ? bal_plus[BAL_W-1:0] : bal_q;
        rej_d     = coin_any && (!in_accept || coin_ovf);
        sel_valid = int'(sel) < N_PRODUCTS;
        sel_price = sel_valid ? price_at(cost, int'(sel)) : '0;
        sel_inv   = sel_valid ? inv_q[sel] : '0;
        cur_price = price_at(cost, int'(idx_q));
    end

    // Transaction FSM: payment, vend, and change ejection.
    always_comb begin
        state_d      = state_q;
        bal_d        = bal_q;
        idx_d        = idx_q;
        card_d       = card_q;
        quart_d      = quart_q;
        dim_d        = dim_q;
        nick_d       = nick_q;
        deny_d       = 1'b0;
        sold_d       = 1'b0;
        enter_change = 1'b0;
        unique case (state_q)
            StIdle: begin
                bal_d = bal_acc;
                if (cancel) begin
                    if (bal_acc != '0) begin
                        state_d      = StChange;
                        enter_change = 1'b1;
                    end
                end else if (select) begin
                    if (!sel_valid) begin
                        deny_d = 1'b1;
                    end else if (sel_inv == '0) begin
                        deny_d = 1'b1;
                        sold_d = 1'b1;
                    end else if (pay_card) begin
                        if (SW'(card_credit) >= SW'(sel_price)) begin
                            idx_d   = sel;
                            card_d  = 1'b1;
                            state_d = StVend;
                        end else begin
                            deny_d = 1'b1;
                        end
                    end else begin
                        idx_d   = sel;
                        card_d  = 1'b0;
                        state_d = (SW'(bal_acc) >= SW'(sel_price)) ? StVend : StCollect;
                    end
                end
            end
            StCollect: begin
                bal_d = bal_acc;
                // Cancel takes priority over reaching the price in the same cycle.
                if (cancel) begin
                    state_d      = StChange;
                    enter_change = 1'b1;
                end else if (SW'(bal_acc) >= SW'(cur_price)) begin
                    state_d = StVend;
                end
            end
            StVend: begin
                state_d = StIdle;
                if (!card_q) begin
                    // Clamp guards against a price raised between select and vend.
                    bal_d = (bal_ext >= SW'(cur_price)) ? bal_q - BAL_W'(cur_price) : '0;
                    if (bal_d != '0) begin
                        state_d      = StChange;
                        enter_change = 1'b1;
                    end
                end
            end
            StChange: begin
                if (bal_ext >= SW'(25)) begin
                    bal_d   = bal_q - BAL_W'(25);
                    quart_d = sat_inc(quart_q);
                end else if (bal_ext >= SW'(10)) begin
                    bal_d = bal_q - BAL_W'(10);
                    dim_d = sat_inc(dim_q);
                end else if (bal_ext >= SW'(5)) begin
                    bal_d  = bal_q - BAL_W'(5);
                    nick_d = sat_inc(nick_q);
                end else begin
                    bal_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (enter_change) begin
            quart_d = '0;
            dim_d   = '0;
            nick_d  = '0;
        end
    end

    // Inventory update: vend decrement and restock may hit the same slot in one cycle.
    always_comb begin
        for (int k = 0; k < N_PRODUCTS; k++) begin
            logic [INV_W:0] sum;
            sum = {1'b0, inv_q[k]};
            if ((state_q == StVend) && (int'(idx_q) == k) && (inv_q[k] != '0)) begin
                sum = sum - InvOne;
            end
            if (restock_en && (int'(restock_idx) == k)) begin
                sum = sum + {1'b0, restock_qty};
            end
            inv_d[k] = (sum > InvMax) ? InvMax[INV_W-1:0] : sum[INV_W-1:0];
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            bal_q   <= '0;
            idx_q   <= '0;
            card_q  <= 1'b0;
            quart_q <= '0;
            dim_q   <= '0;
            nick_q  <= '0;
            deny_q  <= 1'b0;
            sold_q  <= 1'b0;
            rej_q   <= 1'b0;
            for (int k = 0; k < N_PRODUCTS; k++) begin
                inv_q[k] <= INV_W'(INIT_STOCK);
            end
        end else begin
            state_q <= state_d;
            bal_q   <= bal_d;
            idx_q   <= idx_d;
            card_q  <= card_d;
            quart_q <= quart_d;
            dim_q   <= dim_d;
            nick_q  <= nick_d;
            deny_q  <= deny_d;
            sold_q  <= sold_d;
            rej_q   <= rej_d;
            for (int k = 0; k < N_PRODUCTS; k++) begin
                inv_q[k] <= inv_d[k];
            end
        end
    end

    // Output decode from registered state.
    always_comb begin
        in_vend       = (state_q == StVend);
        in_change     = (state_q == StChange);
        balance       = bal_q;
        dispensed     = in_vend;
        dispensed_idx = in_vend ? idx_q : '0;
        card_debit    = (in_vend && card_q) ? BAL_W'(cur_price) : '0;
        deny          = deny_q;
        sold_out      = sold_q;
        coin_reject   = rej_q;
        coin_q        = in_change && (bal_ext >= SW'(25));
        coin_d        = in_change && (bal_ext < SW'(25)) && (bal_ext >= SW'(10));
        coin_n        = in_change && (bal_ext < SW'(10)) && (bal_ext >= SW'(5));
        quart         = quart_q;
        dim           = dim_q;
        nick          = nick_q;
        busy          = in_vend || in_change;
        inventory     = '0;
        for (int k = 0; k < N_PRODUCTS; k++) begin
            inventory[k*INV_W +: INV_W] = inv_q[k];
        end
    end

endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level reference model.
module tb_vending_machine_multi;

    localparam int NP = 8;
    localparam int PW = 8;
    localparam int IW = 3;
    localparam int BW = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [2:0]      sel;
    logic            select, pay_card;
    logic [BW-1:0]   card_credit;
    logic            nickel, dime, quarter, dollar, cancel;
    logic [NP*PW-1:0] cost;
    logic            restock_en;
    logic [2:0]      restock_idx;
    logic [IW-1:0]   restock_qty;
    logic [BW-1:0]   balance;
    logic            dispensed;
    logic [2:0]      dispensed_idx;
    logic [BW-1:0]   card_debit;
    logic            deny, sold_out, coin_reject, coin_q, coin_d, coin_n;
    logic [4:0]      quart, dim, nick;
    logic            busy;
    logic [NP*IW-1:0] inventory;

    vending_machine_multi #(
        .N_PRODUCTS(NP), .PRICE_W(PW), .INV_W(IW), .BAL_W(BW), .INIT_STOCK(4)
    ) dut (
        .clk(clk), .rst(rst), .sel(sel), .select(select), .pay_card(pay_card),
        .card_credit(card_credit), .nickel(nickel), .dime(dime), .quarter(quarter),
        .dollar(dollar), .cancel(cancel), .cost(cost), .restock_en(restock_en),
        .restock_idx(restock_idx), .restock_qty(restock_qty), .balance(balance),
        .dispensed(dispensed), .dispensed_idx(dispensed_idx), .card_debit(card_debit),
        .deny(deny), .sold_out(sold_out), .coin_reject(coin_reject), .coin_q(coin_q),
        .coin_d(coin_d), .coin_n(coin_n), .quart(quart), .dim(dim), .nick(nick),
        .busy(busy), .inventory(inventory)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: money in cents, a queue of change coins still owed.
    int  m_bal, m_idx, m_q, m_d, m_n;
    bit  m_coll, m_vend, m_card, m_chg, m_deny, m_sold, m_rej;
    int  m_inv[NP];
    int  m_change[$];

    function automatic int price_of(input int k);
        return int'(cost[k*PW +: PW]);
    endfunction

    function automatic int inv_slot(input int k);
        return int'(inventory[k*IW +: IW]);
    endfunction

    task automatic start_change();
        int b;
        m_chg = 1; m_q = 0; m_d = 0; m_n = 0;
        m_change.delete();
        b = m_bal;
        while (b >= 25) begin m_change.push_back(25); b -= 25; end
        while (b >= 10) begin m_change.push_back(10); b -= 10; end
        while (b >= 5)  begin m_change.push_back(5);  b -= 5;  end
    endtask

    task automatic model_step();
        int coins, acc, coin, v, old_idx;
        bit was_vend, accepting;
        if (!rst) begin
            m_bal = 0; m_idx = 0; m_q = 0; m_d = 0; m_n = 0;
            m_coll = 0; m_vend = 0; m_card = 0; m_chg = 0;
            m_deny = 0; m_sold = 0; m_rej = 0;
            m_change.delete();
            for (int k = 0; k < NP; k++) m_inv[k] = 4;
            return;
        end
        was_vend  = m_vend;
        old_idx   = m_idx;
        coins     = 5*nickel + 10*dime + 25*quarter + 100*dollar;
        accepting = !m_vend && !m_chg;
        m_rej     = (coins > 0) && (!accepting || (m_bal + coins > 511));
        acc       = (accepting && coins > 0 && (m_bal + coins <= 511)) ? m_bal + coins : m_bal;
        m_deny    = 0;
        m_sold    = 0;
        if (m_vend) begin
            m_vend = 0;
            if (!m_card) begin
                m_bal = (m_bal >= price_of(m_idx)) ? m_bal - price_of(m_idx) : 0;
                if (m_bal > 0) start_change();
            end
        end else if (m_chg) begin
            if (m_change.size() > 0) begin
                coin = m_change.pop_front();
                m_bal -= coin;
                if (coin == 25) m_q = (m_q < 31) ? m_q + 1 : 31;
                if (coin == 10) m_d = (m_d < 31) ? m_d + 1 : 31;
                if (coin == 5)  m_n = (m_n < 31) ? m_n + 1 : 31;
            end else begin
                m_chg = 0;
                m_bal = 0;
            end
        end else if (m_coll) begin
            m_bal = acc;
            if (cancel) begin
                m_coll = 0;
                start_change();
            end else if (m_bal >= price_of(m_idx)) begin
                m_coll = 0;
                m_vend = 1;
            end
        end else begin
            m_bal = acc;
            if (cancel) begin
                if (m_bal > 0) start_change();
            end else if (select) begin
                if (m_inv[sel] == 0) begin
                    m_deny = 1; m_sold = 1;
                end else if (pay_card) begin
                    if (int'(card_credit) >= price_of(int'(sel))) begin
                        m_idx = int'(sel); m_card = 1; m_vend = 1;
                    end else begin
                        m_deny = 1;
                    end
                end else begin
                    m_idx = int'(sel); m_card = 0;
                    if (m_bal >= price_of(m_idx)) m_vend = 1;
                    else m_coll = 1;
                end
            end
        end
        for (int k = 0; k < NP; k++) begin
            v = m_inv[k];
            if (was_vend && k == old_idx && v > 0) v--;
            if (restock_en && int'(restock_idx) == k) v += int'(restock_qty);
            m_inv[k] = (v > 7) ? 7 : v;
        end
    endtask

    task automatic compare_all();
        logic [NP*IW-1:0] exp_inv;
        int head;
        head = (m_chg && m_change.size() > 0) ? m_change[0] : 0;
        for (int k = 0; k < NP; k++) exp_inv[k*IW +: IW] = IW'(m_inv[k]);
        check_eq("balance", balance, m_bal);
        check_eq("dispensed", dispensed, m_vend);
        check_eq("dispensed_idx", dispensed_idx, m_vend ? m_idx : 0);
        check_eq("card_debit", card_debit, (m_vend && m_card) ? price_of(m_idx) : 0);
        check_eq("deny", deny, m_deny);
        check_eq("sold_out", sold_out, m_sold);
        check_eq("coin_reject", coin_reject, m_rej);
        check_eq("coin_q", coin_q, head == 25);
        check_eq("coin_d", coin_d, head == 10);
        check_eq("coin_n", coin_n, head == 5);
        check_eq("quart", quart, m_q);
        check_eq("dim", dim, m_d);
        check_eq("nick", nick, m_n);
        check_eq("busy", busy, m_vend || m_chg);
        check_eq("inventory", inventory, exp_inv);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic clear_pulses();
        select = 0; nickel = 0; dime = 0; quarter = 0; dollar = 0; cancel = 0;
        restock_en = 0;
    endtask

    int cq, cd, cn, cdisp;

    initial begin
        rst = 0; sel = 0; pay_card = 0; card_credit = 0; restock_idx = 0; restock_qty = 0;
        clear_pulses();
        for (int k = 0; k < NP; k++) cost[k*PW +: PW] = 8'd100;

        // Reset for two cycles
        tick(); tick();
        rst = 1;
        check_eq("rst_balance", balance, 0);
        check_eq("rst_inventory", inventory, {NP{3'd4}});
        check_eq("rst_busy", busy, 0);

        // Coin vend of slot 2 at exact price
        sel = 2; select = 1; tick(); clear_pulses();
        check_eq("t2_collect_busy", busy, 0);
        dollar = 1; tick(); clear_pulses();
        check_eq("t2_dispensed", dispensed, 1);
        check_eq("t2_idx", dispensed_idx, 2);
        tick();
        check_eq("t2_inv2", inv_slot(2), 3);
        check_eq("t2_idle", busy, 0);

        // Overpay 105 for a 65c item: change 25,10,5
        cost[1*PW +: PW] = 8'd65;
        sel = 1; select = 1; dollar = 1; nickel = 1; tick(); clear_pulses();
        check_eq("t3_dispensed", dispensed, 1);
        tick(); check_eq("t3_coin_q", coin_q, 1);
        tick(); check_eq("t3_coin_d", coin_d, 1);
        tick(); check_eq("t3_coin_n", coin_n, 1);
        tick();
        check_eq("t3_quart", quart, 1);
        check_eq("t3_dim", dim, 1);
        check_eq("t3_nick", nick, 1);
        check_eq("t3_balance", balance, 0);
        tick(); check_eq("t3_idle", busy, 0);
        cost[1*PW +: PW] = 8'd100;

        // Cancel mid-collect refunds 60c as q,q,d
        sel = 4; select = 1; tick(); clear_pulses();
        quarter = 1; tick(); tick(); clear_pulses();
        dime = 1; tick(); clear_pulses();
        check_eq("t4_balance60", balance, 60);
        cancel = 1; tick(); clear_pulses();
        cq = coin_q; cd = coin_d; cn = coin_n; cdisp = dispensed;
        for (int i = 0; i < 5; i++) begin
            tick();
            cq += coin_q; cd += coin_d; cn += coin_n; cdisp += dispensed;
        end
        check_eq("t4_quarters", cq, 2);
        check_eq("t4_dimes", cd, 1);
        check_eq("t4_nickels", cn, 0);
        check_eq("t4_no_vend", cdisp, 0);
        check_eq("t4_balance0", balance, 0);

        // Card payment: enough credit, then too little
        pay_card = 1; card_credit = 200; sel = 3; select = 1; tick(); clear_pulses();
        check_eq("t5_dispensed", dispensed, 1);
        check_eq("t5_debit", card_debit, 100);
        tick();
        check_eq("t5_no_change", busy, 0);
        card_credit = 50; select = 1; tick(); clear_pulses();
        check_eq("t5_deny", deny, 1);
        check_eq("t5_inv3", inv_slot(3), 3);

        // Sell out slot 0, restock with saturation, then overflow rejection
        card_credit = 200; sel = 0;
        for (int i = 0; i < 4; i++) begin
            select = 1; tick(); clear_pulses(); tick();
        end
        check_eq("t6_inv0_empty", inv_slot(0), 0);
        select = 1; tick(); clear_pulses();
        check_eq("t6_deny", deny, 1);
        check_eq("t6_sold_out", sold_out, 1);
        restock_en = 1; restock_idx = 0; restock_qty = 3; tick(); clear_pulses();
        check_eq("t6_restock3", inv_slot(0), 3);
        restock_en = 1; restock_qty = 7; tick(); clear_pulses();
        check_eq("t6_restock_sat", inv_slot(0), 7);
        pay_card = 0;
        for (int i = 0; i < 5; i++) begin
            dollar = 1; tick(); clear_pulses();
        end
        check_eq("t6_balance500", balance, 500);
        dollar = 1; tick(); clear_pulses();
        check_eq("t6_reject", coin_reject, 1);
        check_eq("t6_balance_kept", balance, 500);
        cancel = 1; tick(); clear_pulses();
        for (int i = 0; i < 24; i++) tick();
        check_eq("t6_drained", busy, 0);

        // Reset during change abandons the refund
        dollar = 1; tick(); clear_pulses();
        cancel = 1; tick(); clear_pulses();
        tick();
        rst = 0; tick(); rst = 1;
        check_eq("t7_balance", balance, 0);
        check_eq("t7_busy", busy, 0);
        check_eq("t7_inv0", inv_slot(0), 4);

        // Random traffic against the model
        for (int k = 0; k < NP; k++) cost[k*PW +: PW] = PW'($urandom_range(20, 200));
        for (int i = 0; i < 3000; i++) begin
            sel         = 3'($urandom_range(0, 7));
            select      = ($urandom_range(0, 99) < 15);
            pay_card    = 1'($urandom_range(0, 1));
            card_credit = BW'($urandom_range(0, 511));
            nickel      = ($urandom_range(0, 9) == 0);
            dime        = ($urandom_range(0, 9) == 0);
            quarter     = ($urandom_range(0, 7) == 0);
            dollar      = ($urandom_range(0, 19) == 0);
            cancel      = ($urandom_range(0, 39) == 0);
            restock_en  = ($urandom_range(0, 29) == 0);
            restock_idx = 3'($urandom_range(0, 7));
            restock_qty = IW'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) begin
                cost[$urandom_range(0, NP-1)*PW +: PW] = PW'($urandom_range(0, 255));
            end
            tick();
        end
        clear_pulses();
        tick();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
